// File: rtl/hp_life_manager.sv
// Boss HP / player lives bookkeeping with player i-frames and a boss phase indicator.
// Optional boss HP regeneration is enabled by defining BOSS_REGEN_EN.
module hp_life_manager #(
  parameter int unsigned BOSS_MAX_HP   = 500,
  parameter int unsigned PLAYER_LIVES  = 3,
  parameter int unsigned IFRAME_CYCLES = 24,
  parameter int unsigned PHASE1_HP     = 333,
  parameter int unsigned PHASE2_HP     = 166,
  parameter int unsigned REGEN_PERIOD  = 48
) (
  input  logic       clk_22,
  input  logic       rst,
  input  logic [1:0] scene,
  input  logic       gamestart,
  input  logic       boss_hit,
  input  logic [3:0] dmg,
  input  logic       player_hit,
  output logic [9:0] bosshp,
  output logic [1:0] life,
  output logic       invincible,
  output logic [1:0] boss_phase
);

  localparam logic [9:0] MAX_HP   = 10'(BOSS_MAX_HP);
  localparam logic [1:0] LIVES    = 2'(PLAYER_LIVES);
  localparam logic [7:0] IFR_LOAD = 8'(IFRAME_CYCLES - 1);
  localparam logic [9:0] P1_HP    = 10'(PHASE1_HP);
  localparam logic [9:0] P2_HP    = 10'(PHASE2_HP);
  localparam logic [1:0] SCENE_GAME = 2'b01;

  logic       active;
  logic       boss_ok;
  logic       player_ok;
  logic [9:0] dmg_ext;
  logic [9:0] hp_after_hit;
  logic [9:0] bosshp_d;
  logic [1:0] life_d;
  logic       invincible_d;
  logic [7:0] ifr_cnt, ifr_cnt_d;

  assign active  = (scene == SCENE_GAME);
  assign dmg_ext = {6'd0, dmg};

  // Gating uses pre-edge values so simultaneous hits resolve independently.
  assign boss_ok   = active && boss_hit && (bosshp != 10'd0) && (life != 2'd0);
  assign player_ok = active && player_hit && !invincible &&
                     (life != 2'd0) && (bosshp != 10'd0);

  assign hp_after_hit = (bosshp > dmg_ext) ? (bosshp - dmg_ext) : 10'd0;

`ifdef BOSS_REGEN_EN
  localparam int unsigned RW = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
  localparam logic [RW-1:0] REGEN_LAST = RW'(REGEN_PERIOD - 1);

  logic [RW-1:0] regen_cnt, regen_cnt_d;
  logic          regen_fire;

  assign regen_fire = (regen_cnt == REGEN_LAST);

  always_comb begin
    regen_cnt_d = regen_cnt;
    if (gamestart) begin
      regen_cnt_d = '0;
    end else if (active) begin
      if (boss_ok || regen_fire) regen_cnt_d = '0;
      else                       regen_cnt_d = regen_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) regen_cnt <= '0;
    else      regen_cnt <= regen_cnt_d;
  end
`else
  logic unused_regen_cfg;
  assign unused_regen_cfg = (REGEN_PERIOD == 0);
`endif

  always_comb begin
    bosshp_d     = bosshp;
    life_d       = life;
    invincible_d = invincible;
    ifr_cnt_d    = ifr_cnt;
    if (gamestart) begin
      bosshp_d     = MAX_HP;
      life_d       = LIVES;
      invincible_d = 1'b0;
      ifr_cnt_d    = 8'd0;
    end else if (active) begin
      if (boss_ok) begin
        bosshp_d = hp_after_hit;
      end
`ifdef BOSS_REGEN_EN
      // A hit in the same cycle suppresses regen; a dead boss never regenerates.
      else if (regen_fire && (bosshp != 10'd0) && (bosshp < MAX_HP)) begin
        bosshp_d = bosshp + 10'd1;
      end
`endif
      if (player_ok) begin
        life_d       = life - 2'd1;
        invincible_d = 1'b1;
        ifr_cnt_d    = IFR_LOAD;
      end else if (invincible) begin
        if (ifr_cnt == 8'd0) invincible_d = 1'b0;
        else                 ifr_cnt_d    = ifr_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      bosshp     <= MAX_HP;
      life       <= LIVES;
      invincible <= 1'b0;
      ifr_cnt    <= 8'd0;
    end else begin
      bosshp     <= bosshp_d;
      life       <= life_d;
      invincible <= invincible_d;
      ifr_cnt    <= ifr_cnt_d;
    end
  end

  always_comb begin
    if (bosshp == 10'd0)      boss_phase = 2'd3;
    else if (bosshp <= P2_HP) boss_phase = 2'd2;
    else if (bosshp <= P1_HP) boss_phase = 2'd1;
    else                      boss_phase = 2'd0;
  end

endmodule

// File: tb/tb_hp_life_manager.sv
// Self-checking bench for hp_life_manager: directed scenarios plus randomized traffic
// compared against a behavioural model of HP, lives and remaining i-frame time.
module tb_hp_life_manager;

  localparam int MAX_HP  = 500;
  localparam int LIVES   = 3;
  localparam int IFRAMES = 24;
  localparam int P1      = 333;
  localparam int P2      = 166;
  localparam int PERIOD  = 48;

  logic       clk_22 = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] scene = 2'b00;
  logic       gamestart = 1'b0;
  logic       boss_hit = 1'b0;
  logic [3:0] dmg = 4'd0;
  logic       player_hit = 1'b0;
  logic [9:0] bosshp;
  logic [1:0] life;
  logic       invincible;
  logic [1:0] boss_phase;

  int tests_run = 0;
  int fail_count = 0;

  // model state
  int m_hp, m_life, m_inv_left, m_regen;

  hp_life_manager dut (
    .clk_22(clk_22), .rst(rst), .scene(scene), .gamestart(gamestart),
    .boss_hit(boss_hit), .dmg(dmg), .player_hit(player_hit),
    .bosshp(bosshp), .life(life), .invincible(invincible), .boss_phase(boss_phase)
  );

  always #5 clk_22 = ~clk_22;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      fail_count++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_phase(input int hp);
    if (hp == 0) return 3;
    if (hp <= P2) return 2;
    if (hp <= P1) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_hp = MAX_HP; m_life = LIVES; m_inv_left = 0; m_regen = 0;
  endtask

  task automatic model_step(input logic [1:0] sc, input logic gs, input logic bh,
                            input int d, input logic ph);
    bit b_acc, p_acc;
    int new_hp;
    if (gs) begin
      model_reset();
    end else if (sc == 2'b01) begin
      b_acc = bh && m_hp != 0 && m_life != 0;
      p_acc = ph && m_inv_left == 0 && m_life != 0 && m_hp != 0;
      new_hp = m_hp;
      if (b_acc) new_hp = (d >= m_hp) ? 0 : m_hp - d;
`ifdef BOSS_REGEN_EN
      if (b_acc) m_regen = 0;
      else if (m_regen == PERIOD - 1) begin
        if (m_hp > 0 && m_hp < MAX_HP) new_hp = m_hp + 1;
        m_regen = 0;
      end else m_regen++;
`endif
      m_hp = new_hp;
      if (p_acc) begin
        m_life--;
        m_inv_left = IFRAMES;
      end else if (m_inv_left > 0) m_inv_left--;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".hp"}, int'(bosshp), m_hp);
    check({tag, ".life"}, int'(life), m_life);
    check({tag, ".inv"}, int'(invincible), (m_inv_left > 0) ? 1 : 0);
    check({tag, ".phase"}, int'(boss_phase), exp_phase(m_hp));
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic cycle(input logic [1:0] sc, input logic gs, input logic bh,
                       input logic [3:0] d, input logic ph, input string tag);
    scene = sc; gamestart = gs; boss_hit = bh; dmg = d; player_hit = ph;
    @(posedge clk_22);
    model_step(sc, gs, bh, int'(d), ph);
    #1;
    compare_all(tag);
    gamestart = 1'b0; boss_hit = 1'b0; player_hit = 1'b0; dmg = 4'd0;
  endtask

  task automatic idle(input int n, input logic [1:0] sc, input string tag);
    for (int i = 0; i < n; i++) cycle(sc, 1'b0, 1'b0, 4'd0, 1'b0, tag);
  endtask

  task automatic hit_down_to(input int target);
    int d;
    while (m_hp > target) begin
      d = (m_hp - target > 15) ? 15 : m_hp - target;
      cycle(2'b01, 1'b0, 1'b1, 4'(d), 1'b0, "hitdown");
    end
  endtask

  task automatic do_async_reset(input string tag);
    @(negedge clk_22);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk_22);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk_22);
    rst = 1'b1;

    // 1: start
    cycle(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, "start");
    check("start_hp", int'(bosshp), 500);
    check("start_phase", int'(boss_phase), 0);

    // 2: saturating damage
    hit_down_to(10);
    cycle(2'b01, 1'b0, 1'b1, 4'd7, 1'b0, "dmg7a");
    check("hp_3", int'(bosshp), 3);
    cycle(2'b01, 1'b0, 1'b1, 4'd7, 1'b0, "dmg7b");
    check("hp_sat0", int'(bosshp), 0);
    check("phase_dead", int'(boss_phase), 3);
    cycle(2'b01, 1'b0, 1'b1, 4'd9, 1'b0, "dmg_dead");
    cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b1, "ph_dead");
    check("life_dead_boss", int'(life), 3);

    // 3: i-frames
    cycle(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, "gs3");
    cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b1, "ph1");
    check("life_2", int'(life), 2);
    n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b0, "ifr");
      if (invincible) n++;
    end
    cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b1, "ph_ignored");
    if (invincible) n++;
    check("life_still_2", int'(life), 2);
    for (int i = 0; i < 40 && invincible; i++) begin
      cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b0, "ifr");
      if (invincible) n++;
    end
    check("iframe_len", n, IFRAMES);
    cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b1, "ph2");
    check("life_1", int'(life), 1);

    // 4: simultaneous hits
    cycle(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, "gs4");
    hit_down_to(400);
    cycle(2'b01, 1'b0, 1'b1, 4'd15, 1'b1, "both");
    check("both_hp", int'(bosshp), 385);
    check("both_life", int'(life), 2);
    check("both_inv", int'(invincible), 1);

    // 5: freeze mid i-frame (counter 23 -> 10 after 13 edges)
    idle(13, 2'b01, "pre_freeze");
    idle(30, 2'b10, "frozen");
    check("frozen_inv", int'(invincible), 1);
    n = 0;
    for (int i = 0; i < 40 && invincible; i++) begin
      cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b0, "thaw");
      n++;
    end
    check("thaw_len", n, 11);
    for (int k = 0; k < 2; k++) begin
      cycle(2'b01, 1'b0, 1'b0, 4'd0, 1'b1, "kill");
      idle(IFRAMES, 2'b01, "kill_ifr");
    end
    check("life_0", int'(life), 0);
    n = int'(bosshp);
    cycle(2'b01, 1'b0, 1'b1, 4'd12, 1'b0, "bh_lost");
    check("hp_hold_lost", int'(bosshp), n);

    // 6: async reset mid-game
    cycle(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, "gs6");
    hit_down_to(50);
    do_async_reset("async_rst");
    check("rst_hp", int'(bosshp), 500);
`ifdef BOSS_REGEN_EN
    cycle(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, "gs_regen");
    hit_down_to(100);
    idle(47, 2'b01, "regen_wait");
    check("regen_not_yet", int'(bosshp), 100);
    idle(1, 2'b01, "regen");
    check("regen_101", int'(bosshp), 101);
`endif

    // randomized traffic
    cycle(2'b01, 1'b1, 1'b0, 4'd0, 1'b0, "gs_rand");
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] sc;
      sc = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) do_async_reset("rand_rst");
      cycle(sc, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35,
            4'($urandom_range(0, 15)), $urandom_range(0, 99) < 8, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
